// File: rtl/event_pkg.sv
// Shared definitions for the event frame transmitter: event codes, timestamp
// width, frame layout and the transmit FSM state type.
package event_pkg;

   localparam logic [1:0] EV_NONE = 2'b00;

   localparam int CODE_W  = 2;
   localparam int TS_W    = 12;
   localparam int TS_LO_W = 7;
   localparam int ENTRY_W = CODE_W + TS_W;

   localparam int   FRAME_MARK_POS = 7;
   localparam logic MARK_BYTE0     = 1'b1;
   localparam logic MARK_BYTE1     = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BYTE0 = 2'b01,
      BYTE1 = 2'b10
   } tx_state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [TS_W-1:0]   ts;
   } event_entry_t;

   // Byte0 carries the marker, the class and the timestamp high bits.
   function automatic logic [7:0] frame_byte0(input event_entry_t e);
      return {MARK_BYTE0, e.code, e.ts[TS_W-1:TS_LO_W]};
   endfunction

   function automatic logic [7:0] frame_byte1(input logic [TS_LO_W-1:0] ts_lo);
      return {MARK_BYTE1, ts_lo};
   endfunction

endpackage

// File: rtl/event_frame_tx_if.sv
// Byte-wide valid/ready stream toward the off-chip link.
interface event_frame_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module event_fifo
   import event_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == {LW{1'b0}});
   assign pop_ok_s  = pop_i && !empty_o;
   assign push_ok_s = push_i && (!full_o || pop_ok_s);
   assign dout_o    = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/event_frame_tx.sv
// Timestamps new classified events, queues them and serialises each one as a
// marker-synchronised 2-byte frame on a valid/ready byte stream.
module event_frame_tx
   import event_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CODE_W-1:0]       event_in,
   input  logic                    tick_en,
   input  logic                    ovf_clr,
   event_frame_tx_if.master        tx,
   output logic                    overflow,
   output logic [DROP_W-1:0]       drop_count,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   logic [TS_W-1:0]    ts_q, ts_d;
   logic [CODE_W-1:0]  prev_code_q;
   tx_state_e          state_q, state_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic [TS_LO_W-1:0] ts_lo_q, ts_lo_d;
   logic               overflow_q, overflow_d;
   logic [DROP_W-1:0]  drop_count_q, drop_count_d;

   logic               push_s, pop_s, drop_s, full_s, empty_s;
   event_entry_t       entry_s, head_s;
   logic [ENTRY_W-1:0] fifo_dout_s;

   assign push_s  = (event_in != EV_NONE) && (event_in != prev_code_q);
   assign entry_s = '{code: event_in, ts: ts_q};
   assign head_s  = fifo_dout_s;
   assign drop_s  = push_s && full_s && !pop_s;
   assign ts_d    = tick_en ? (ts_q + TS_W'(1)) : ts_q;

   event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .din_i   (entry_s),
      .dout_o  (fifo_dout_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .level_o (fifo_level)
   );

   // Timestamp counter and previous-code register for edge capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q        <= {TS_W{1'b0}};
         prev_code_q <= EV_NONE;
      end else begin
         ts_q        <= ts_d;
         prev_code_q <= event_in;
      end
   end

   // Frame FSM; a pop loads byte0 directly so frames stream without a bubble.
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ts_lo_d    = ts_lo_q;
      pop_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_s) begin
               pop_s      = 1'b1;
               tx_data_d  = frame_byte0(head_s);
               ts_lo_d    = head_s.ts[TS_LO_W-1:0];
               tx_valid_d = 1'b1;
               state_d    = BYTE0;
            end else begin
               tx_valid_d = 1'b0;
            end
         end
         BYTE0: begin
            if (tx.tx_ready) begin
               tx_data_d = frame_byte1(ts_lo_q);
               state_d   = BYTE1;
            end else begin
               state_d = BYTE0;
            end
         end
         BYTE1: begin
            if (tx.tx_ready && !empty_s) begin
               pop_s     = 1'b1;
               tx_data_d = frame_byte0(head_s);
               ts_lo_d   = head_s.ts[TS_LO_W-1:0];
               state_d   = BYTE0;
            end else if (tx.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
            end else begin
               state_d = BYTE1;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // FSM state and registered stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         ts_lo_q    <= {TS_LO_W{1'b0}};
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         ts_lo_q    <= ts_lo_d;
      end
   end

   // A drop in the same cycle as a clear restarts the count at one.
   always_comb begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (drop_s) begin
         overflow_d = 1'b1;
         if (ovf_clr) begin
            drop_count_d = DROP_W'(1);
         end else if (drop_count_q == {DROP_W{1'b1}}) begin
            drop_count_d = drop_count_q;
         end else begin
            drop_count_d = drop_count_q + DROP_W'(1);
         end
      end else if (ovf_clr) begin
         overflow_d   = 1'b0;
         drop_count_d = {DROP_W{1'b0}};
      end else begin
         overflow_d   = overflow_q;
         drop_count_d = drop_count_q;
      end
   end

   // Overflow flag and dropped-event counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q   <= 1'b0;
         drop_count_q <= {DROP_W{1'b0}};
      end else begin
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_event_frame_tx.sv
// Self-checking bench for event_frame_tx: frame vector table plus hand-written
// backpressure, overflow, streaming, wrap and reset sequences.
module tb_event_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] event_in = 2'b00;
   logic       tick_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       overflow;
   logic [7:0] drop_count;
   logic [2:0] fifo_level;

   event_frame_tx_if bus ();

   always #5 clk = ~clk;

   event_frame_tx #(
      .DEPTH  (4),
      .DROP_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .event_in   (event_in),
      .tick_en    (tick_en),
      .ovf_clr    (ovf_clr),
      .tx         (bus),
      .overflow   (overflow),
      .drop_count (drop_count),
      .fifo_level (fifo_level)
   );

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb_q[$];
   logic [11:0] ts_m;
   logic [1:0]  prev_m;

   typedef struct {
      logic [1:0] code;
      int         ts;
      logic [7:0] b0;
      logic [7:0] b1;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, score any handshake at the coming edge,
   // record expected frame bytes for a newly captured event.
   task automatic cyc(input logic [1:0] ev, input logic tick, input logic rdy,
                      input logic clr, input logic keep);
      event_in     = ev;
      tick_en      = tick;
      bus.tx_ready = rdy;
      ovf_clr      = clr;
      if (bus.tx_valid && rdy) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", bus.tx_data);
         end else begin
            check("tx_byte", 32'(bus.tx_data), 32'(sb_q.pop_front()));
         end
      end
      if (ev != 2'b00 && ev != prev_m && keep) begin
         sb_q.push_back({1'b1, ev, ts_m[11:7]});
         sb_q.push_back({1'b0, ts_m[6:0]});
      end
      @(posedge clk);
      #1;
      ts_m   = ts_m + (tick ? 12'd1 : 12'd0);
      prev_m = ev;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      event_in     = 2'b00;
      tick_en      = 1'b0;
      ovf_clr      = 1'b0;
      bus.tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      ts_m   = 12'd0;
      prev_m = 2'b00;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || bus.tx_valid) && n < budget) begin
         cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
         n++;
      end
      check("drain_done", 32'(sb_q.size() == 0 && !bus.tx_valid), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{code: 2'b01, ts: 32'h123, b0: 8'hA2, b1: 8'h23};
      vecs[1] = '{code: 2'b10, ts: 32'hFFF, b0: 8'hDF, b1: 8'h7F};
      vecs[2] = '{code: 2'b11, ts: 32'h000, b0: 8'hE0, b1: 8'h00};
      vecs[3] = '{code: 2'b01, ts: 32'h080, b0: 8'hA1, b1: 8'h00};
      vecs[4] = '{code: 2'b10, ts: 32'h555, b0: 8'hCA, b1: 8'h55};

      // Reset values.
      do_reset();
      check("rst_tx_data", 32'(bus.tx_data), 32'h00);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
      check("rst_fifo_level", 32'(fifo_level), 32'd0);

      // Frame encoding table.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         repeat (vecs[i].ts) cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
         cyc(vecs[i].code, 1'b1, 1'b1, 1'b0, 1'b0);
         sb_q.push_back(vecs[i].b0);
         sb_q.push_back(vecs[i].b1);
         drain(10);
      end

      // Single held event: one frame, valid two edges after capture.
      do_reset();
      repeat (12'h123) cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
      check("single_valid_e0", 32'(bus.tx_valid), 32'd0);
      check("single_level_e0", 32'(fifo_level), 32'd1);
      cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
      check("single_valid_e1", 32'(bus.tx_valid), 32'd1);
      check("single_byte0", 32'(bus.tx_data), 32'hA2);
      cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
      check("single_byte1", 32'(bus.tx_data), 32'h23);
      drain(10);

      // Backpressure on byte0 (event captured at ts=5).
      do_reset();
      repeat (5) cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", 32'(bus.tx_valid), 32'd1);
         check("bp_data", 32'(bus.tx_data), 32'hC0);
         cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      check("bp_byte1", 32'(bus.tx_data), 32'h05);
      check("bp_byte1_valid", 32'(bus.tx_valid), 32'd1);
      drain(10);

      // Overflow: one frame stalled in the FSM, then six events into 4 slots.
      do_reset();
      cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         cyc((k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b0, (k < 4) ? 1'b1 : 1'b0);
      end
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      check("ovf_level", 32'(fifo_level), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_drops", 32'(drop_count), 32'd2);
      cyc(2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
      check("clr_flag", 32'(overflow), 32'd0);
      check("clr_drops", 32'(drop_count), 32'd0);
      drain(30);

      // Drop beats clear in the same cycle, then the counter saturates.
      do_reset();
      cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc((k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      check("drop_one", 32'(drop_count), 32'd1);
      cyc(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
      check("drop_clr_flag", 32'(overflow), 32'd1);
      check("drop_clr_count", 32'(drop_count), 32'd1);
      for (int k = 0; k < 300; k++) begin
         cyc((k % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("drop_saturate", 32'(drop_count), 32'd255);
      check("drop_sat_level", 32'(fifo_level), 32'd4);

      // Back-to-back: three queued frames behind a stalled one.
      do_reset();
      cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      check("b2b_level_start", 32'(fifo_level), 32'd3);
      for (int k = 0; k < 8; k++) begin
         cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
         check("b2b_valid", 32'(bus.tx_valid), (k < 7) ? 32'd1 : 32'd0);
         if (k == 1 || k == 3 || k == 5) begin
            check("b2b_level", 32'(fifo_level), 32'(2 - (k - 1) / 2));
         end
      end
      drain(5);

      // Timestamp wrap: events at ts=4095 and ts=0.
      do_reset();
      repeat (4095) cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
      sb_q.push_back(8'hBF);
      sb_q.push_back(8'h7F);
      sb_q.push_back(8'hC0);
      sb_q.push_back(8'h00);
      drain(20);

      // Asynchronous reset between byte0 and byte1 with a frame still queued.
      do_reset();
      cyc(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      check("mid_valid_before", 32'(bus.tx_valid), 32'd1);
      check("mid_level_before", 32'(fifo_level), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
      check("mid_rst_data", 32'(bus.tx_data), 32'h00);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      ts_m   = 12'd0;
      prev_m = 2'b00;
      for (int k = 0; k < 10; k++) begin
         cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
         check("mid_post_valid", 32'(bus.tx_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
